// File: rtl/mul_div_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// The divide path is built only when MUL_DIV_UNIT_DIVIDE_EN is defined.
package mul_div_pkg;

    // Default operand width: a 32-bit CPU operand sign/zero-extended by one bit.
    localparam int WIDTH_DEF = 33;

    // The iteration counter must be able to hold WIDTH-1.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

    localparam int CNT_W_DEF = cnt_width(WIDTH_DEF);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_FINISH  = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_e;

endpackage

// File: rtl/mul_div_addsub.sv
// Shared adder/subtractor. It does the multiply add and subtract steps
// and the trial subtraction of restoring division.
module mul_div_addsub #(
    parameter int N = 34
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_sub,
    output logic [N-1:0] o_y
);

    // Subtraction is done as a + ~b + 1.
    assign o_y = i_a + (i_b ^ {N{i_sub}}) + {{(N-1){1'b0}}, i_sub};

endmodule

// File: rtl/mul_div_unit.sv
// Iterative signed multiply/divide unit. Each Run request starts one
// operation. The result is returned on the register pair {Aval, Bval}.
// Macro MUL_DIV_UNIT_DIVIDE_EN enables the divide path. Without the macro
// the div input is ignored and every operation is a multiply.
module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             div,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             X,
    output logic             ready
);

    localparam int               CNT_W     = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_e           r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic             r_x, w_x_next;
    logic [WIDTH-1:0] r_a, w_a_next;
    logic [WIDTH-1:0] r_b, w_b_next;
    logic [WIDTH-1:0] r_opa, w_opa_next;

    logic             w_last;
    logic [WIDTH:0]   w_add_a, w_add_b, w_sum, w_acc;
    logic             w_add_sub;

`ifdef MUL_DIV_UNIT_DIVIDE_EN
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    op_e              r_op, w_op_next;
    logic [WIDTH-1:0] r_opm, w_opm_next;      // |divisor|
    logic             r_a_neg, w_a_neg_next;  // dividend sign, which the remainder takes
    logic             r_b_neg, w_b_neg_next;  // divisor sign
    logic             r_q_neg, w_q_neg_next;  // operand signs differ
`else
    logic             w_unused_div;
    assign w_unused_div = div;
`endif

    assign w_last = (r_cnt == LAST_ITER);
    assign Aval   = r_a;
    assign Bval   = r_b;
    assign X      = r_x;

    mul_div_addsub #(.N(WIDTH + 1)) u_addsub (
        .i_a   (w_add_a),
        .i_b   (w_add_b),
        .i_sub (w_add_sub),
        .o_y   (w_sum)
    );

    // Select adder operands. Multiply adds the sign-extended multiplicand
    // and subtracts it on the final, sign-weighted bit. Divide subtracts the
    // divisor magnitude from the shifted partial remainder.
    always_comb begin
        w_add_a   = {r_x, r_a};
        w_add_b   = {r_opa[WIDTH-1], r_opa};
        w_add_sub = w_last;
`ifdef MUL_DIV_UNIT_DIVIDE_EN
        if (r_op == OP_DIV) begin
            w_add_a   = {r_a, r_b[WIDTH-1]};
            w_add_b   = {1'b0, r_opm};
            w_add_sub = 1'b1;
        end
`endif
    end

    // Next-state logic and the busy flag. ready is low only while computing.
    always_comb begin
        w_state_next = r_state;
        ready        = 1'b1;
        case (r_state)
            ST_IDLE:    if (Run) w_state_next = ST_COMPUTE;
            ST_COMPUTE: begin
                ready = 1'b0;
                if (w_last) w_state_next = ST_FINISH;
            end
            ST_FINISH:  begin
                ready        = 1'b0;
                w_state_next = ST_DONE;
            end
            ST_DONE:    if (!Run) w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // Datapath next values: operand capture, one iteration per cycle, and
    // the divide sign fixup.
    always_comb begin
        w_cnt_next = r_cnt;
        w_x_next   = r_x;
        w_a_next   = r_a;
        w_b_next   = r_b;
        w_opa_next = r_opa;
        w_acc      = r_b[0] ? w_sum : {r_x, r_a};
`ifdef MUL_DIV_UNIT_DIVIDE_EN
        w_op_next    = r_op;
        w_opm_next   = r_opm;
        w_a_neg_next = r_a_neg;
        w_b_neg_next = r_b_neg;
        w_q_neg_next = r_q_neg;
`endif
        case (r_state)
            ST_IDLE: begin
                if (Run) begin
                    w_cnt_next = '0;
                    w_x_next   = 1'b0;
                    w_a_next   = '0;
                    w_b_next   = opB;
                    w_opa_next = opA;
`ifdef MUL_DIV_UNIT_DIVIDE_EN
                    w_op_next    = op_e'(div);
                    w_opm_next   = opB[WIDTH-1] ? -opB : opB;
                    w_a_neg_next = opA[WIDTH-1];
                    w_b_neg_next = opB[WIDTH-1];
                    w_q_neg_next = opA[WIDTH-1] ^ opB[WIDTH-1];
                    // The dividend magnitude is shifted out of B from the MSB.
                    if (div) w_b_next = opA[WIDTH-1] ? -opA : opA;
`endif
                end
            end
            ST_COMPUTE: begin
                w_cnt_next = r_cnt + 1'b1;
                // Arithmetic shift right of {X, A, B} after the conditional add.
                w_x_next   = w_acc[WIDTH];
                w_a_next   = w_acc[WIDTH:1];
                w_b_next   = {w_acc[0], r_b[WIDTH-1:1]};
`ifdef MUL_DIV_UNIT_DIVIDE_EN
                if (r_op == OP_DIV) begin
                    // The remainder is always below |divisor|, so it fits in A.
                    // X stays clear.
                    w_x_next = 1'b0;
                    if (!w_sum[WIDTH]) begin
                        w_a_next = w_sum[WIDTH-1:0];
                        w_b_next = {r_b[WIDTH-2:0], 1'b1};
                    end else begin
                        w_a_next = w_add_a[WIDTH-1:0];
                        w_b_next = {r_b[WIDTH-2:0], 1'b0};
                    end
                end
`endif
            end
            ST_FINISH: begin
`ifdef MUL_DIV_UNIT_DIVIDE_EN
                if (r_op == OP_DIV) begin
                    if (r_opm == '0) begin
                        w_b_next = '1;
                        w_a_next = r_opa;
                        w_x_next = r_opa[WIDTH-1];
                    end else if (r_opa == MIN_VAL && r_opm == WIDTH'(1) && r_b_neg) begin
                        w_b_next = r_opa;
                        w_a_next = '0;
                        w_x_next = 1'b0;
                    end else begin
                        w_b_next = r_q_neg ? -r_b : r_b;
                        w_a_next = r_a_neg ? -r_a : r_a;
                        w_x_next = r_a_neg && (r_a != '0);
                    end
                end
`endif
            end
            default: begin
            end
        endcase
    end

    // State and datapath registers. Reset aborts any operation in progress.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_x     <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_opa   <= '0;
`ifdef MUL_DIV_UNIT_DIVIDE_EN
            r_op    <= OP_MUL;
            r_opm   <= '0;
            r_a_neg <= 1'b0;
            r_b_neg <= 1'b0;
            r_q_neg <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_x     <= w_x_next;
            r_a     <= w_a_next;
            r_b     <= w_b_next;
            r_opa   <= w_opa_next;
`ifdef MUL_DIV_UNIT_DIVIDE_EN
            r_op    <= w_op_next;
            r_opm   <= w_opm_next;
            r_a_neg <= w_a_neg_next;
            r_b_neg <= w_b_neg_next;
            r_q_neg <= w_q_neg_next;
`endif
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit. The stimulus process queues expected
// results. The monitor process checks each result on the rising edge of ready.
module tb_mul_div_unit;

    localparam int W    = 33;
    localparam int BUSY = W + 1;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         x;
        int           lat;   // expected busy cycles, -1 = not checked
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         run = 1'b0;
    logic         dv  = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic [W-1:0] aval, bval;
    logic         x_o, rdy;

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(W)) dut (
        .Clk   (clk),
        .Reset (rst),
        .Run   (run),
        .div   (dv),
        .opA   (op_a),
        .opB   (op_b),
        .Aval  (aval),
        .Bval  (bval),
        .X     (x_o),
        .ready (rdy)
    );

    // Reference model: plain signed arithmetic on the operand values.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic d);
        exp_t                    e;
        logic signed [2*W-1:0]   sa, sb, p;
        longint                  la, lb, q, r;
        logic                    unused_d;
        unused_d = d;
        e.lat = BUSY;
`ifdef MUL_DIV_UNIT_DIVIDE_EN
        if (d) begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
            if (lb == 0) begin
                e.b = '1;
                e.a = a;
            end else begin
                q   = la / lb;
                r   = la % lb;
                e.b = q[W-1:0];
                e.a = r[W-1:0];
            end
            e.x = e.a[W-1];
            return e;
        end
`endif
        sa  = {{W{a[W-1]}}, a};
        sb  = {{W{b[W-1]}}, b};
        p   = sa * sb;
        e.a = p[2*W-1:W];
        e.b = p[W-1:0];
        e.x = p[2*W-1];
        return e;
    endfunction

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    function automatic logic [W-1:0] rnd_op();
        logic [31:0] v;
        v = $urandom();
        case ($urandom_range(0, 3))
            0:       return {v[31], v};
            1:       return {1'b0, v};
            2:       return W'($urandom_range(0, 40)) - W'(20);
            default: return {1'b0, 16'h0, v[15:0]};
        endcase
    endfunction

    // Monitor: a rising edge of ready presents one result.
    logic prev_rdy = 1'b1;
    int   busy_cnt = 0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (rdy === 1'b1 && prev_rdy === 1'b0) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got A=%h B=%h required no result", aval, bval);
            end else begin
                mon_e = sb_q.pop_front();
                check("aval", aval, mon_e.a);
                check("bval", bval, mon_e.b);
                check("x", W'(x_o), W'(mon_e.x));
                if (mon_e.lat >= 0) check("busy_cycles", W'(busy_cnt), W'(mon_e.lat));
                $display("result A=%h B=%h X=%b busy=%0d", aval, bval, x_o, busy_cnt);
            end
            busy_cnt = 0;
        end else if (rdy === 1'b0) begin
            busy_cnt++;
        end
        prev_rdy = rdy;
    end

    // Start one operation, scramble inputs while busy, optionally hold Run in DONE.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic d, input int hold);
        exp_t e;
        int   n;
        e = model(a, b, d);
        @(negedge clk);
        op_a = a;
        op_b = b;
        dv   = d;
        run  = 1'b1;
        sb_q.push_back(e);
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (rdy === 1'b1 && n > 1) break;
            op_a = rnd_op();
            op_b = rnd_op();
            dv   = 1'($urandom_range(0, 1));
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got ready=%b required 1 within 200 cycles", rdy);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_ready", W'(rdy), W'(1));
            check("hold_aval", aval, e.a);
            check("hold_bval", bval, e.b);
        end
        run = 1'b0;
        @(negedge clk);
    endtask

    // Start an operation and abort it with reset partway through COMPUTE.
    task automatic abort_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic d);
        exp_t e;
        e = '{a: '0, b: '0, x: 1'b0, lat: -1};
        @(negedge clk);
        op_a = a;
        op_b = b;
        dv   = d;
        run  = 1'b1;
        sb_q.push_back(e);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        run = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", W'(rdy), W'(1));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got no finish required finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_aval", aval, '0);
        check("reset_bval", bval, '0);
        check("reset_x", W'(x_o), '0);
        check("reset_ready", W'(rdy), W'(1));

        run_op(33'd12, 33'd4, 1'b0, 4);
        run_op(33'h1_FFFF_FFFD, 33'd5, 1'b0, 0);
        run_op(33'd12, 33'd4, 1'b1, 0);
        run_op(33'h1_FFFF_FFF9, 33'd2, 1'b1, 0);
        run_op(33'd12, 33'd0, 1'b1, 0);
        run_op(33'h1_0000_0000, 33'h1_FFFF_FFFF, 1'b1, 0);
        run_op(33'd7, 33'h1_FFFF_FFFE, 1'b1, 0);
        run_op(33'h1_FFFF_FFF9, 33'h1_FFFF_FFFE, 1'b1, 0);
        run_op(33'h1_0000_0000, 33'h1_0000_0000, 1'b0, 0);
        run_op(33'h1_0000_0000, 33'h1_FFFF_FFFF, 1'b0, 0);
        run_op(33'h0_FFFF_FFFF, 33'h0_FFFF_FFFF, 1'b0, 0);
        abort_op(33'd5, 33'd6, 1'b0);
        run_op(33'd100, 33'h1_FFFF_FFF7, 1'b0, 0);
        for (int k = 0; k < 24; k++) begin
            logic [W-1:0] ra, rb;
            ra = rnd_op();
            rb = ($urandom_range(0, 9) == 0) ? '0 : rnd_op();
            run_op(ra, rb, 1'($urandom_range(0, 1)), 0);
        end

        repeat (3) @(negedge clk);
        check("queue_empty", W'(sb_q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
